led_pulse_stretch: RTL and testbench

LED_PULSE_STRETCH -- requirements
Module: led_pulse_stretch

---
 rtl/led_pulse_stretch.sv | 137 +++++++++++++
 tb/tb_led_pulse_stretch.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/led_pulse_stretch.sv
// Stretches single-cycle event strobes into fixed-length LED flashes separated
// by a minimum dark gap, queueing events that arrive while a flash is in progress.
module led_pulse_stretch #(
    parameter int ON_CYCLES  = 1_000_000,
    parameter int OFF_CYCLES = 500_000,
    parameter int PEND_MAX   = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       evt_in,
    input  logic       ovf_clr,
    output logic       led_out,
    output logic       busy,
    output logic [2:0] pend_cnt,
    output logic       overflow
);

    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // The counter is loaded with length-1 on entry and the phase ends when it hits zero.
    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       PEND_LIM = 3'(PEND_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       pend_reg, pend_next;
    logic             ovf_reg, ovf_next;
    logic             led_reg, led_next;

    logic phase_done;
    logic pend_full;
    logic pend_empty;
    logic ovf_set;

    assign phase_done = (cnt_reg == '0);
    assign pend_full  = (pend_reg == PEND_LIM);
    assign pend_empty = (pend_reg == 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            pend_reg  <= 3'd0;
            ovf_reg   <= 1'b0;
            led_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pend_reg  <= pend_next;
            ovf_reg   <= ovf_next;
            led_reg   <= led_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pend_next  = pend_reg;
        ovf_set    = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (evt_in) begin
                    state_next = ST_ON;
                    cnt_next   = ON_LOAD;
                end
            end

            ST_ON: begin
                if (evt_in) begin
                    if (pend_full) begin
                        ovf_set = 1'b1;
                    end else begin
                        pend_next = pend_reg + 3'd1;
                    end
                end
                if (phase_done) begin
                    state_next = ST_GAP;
                    cnt_next   = OFF_LOAD;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end

            ST_GAP: begin
                if (phase_done) begin
                    // A same-cycle event replaces the dequeued one, so the queue depth
                    // only drops when no new event arrives.
                    if (!pend_empty || evt_in) begin
                        state_next = ST_ON;
                        cnt_next   = ON_LOAD;
                        if (!pend_empty && !evt_in) begin
                            pend_next = pend_reg - 3'd1;
                        end
                    end else begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                    if (evt_in) begin
                        if (pend_full) begin
                            ovf_set = 1'b1;
                        end else begin
                            pend_next = pend_reg + 3'd1;
                        end
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                pend_next  = 3'd0;
            end
        endcase
    end

    // Set has priority over clear so a drop coinciding with a clear is never lost.
    assign ovf_next = ovf_set | (ovf_reg & ~ovf_clr);
    assign led_next = (state_next == ST_ON);

    assign led_out  = led_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign pend_cnt = pend_reg;
    assign overflow = ovf_reg;

endmodule

// File: tb/tb_led_pulse_stretch.sv
// Directed scenarios for led_pulse_stretch (ON=4, OFF=3, PEND_MAX=3); each character
// of a pattern string is one clock cycle, checked by a queue-based monitor.
module tb_led_pulse_stretch;

    logic       clk;
    logic       rst;
    logic       evt_in;
    logic       ovf_clr;
    logic       led_out;
    logic       busy;
    logic [2:0] pend_cnt;
    logic       overflow;

    led_pulse_stretch #(
        .ON_CYCLES  (4),
        .OFF_CYCLES (3),
        .PEND_MAX   (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .evt_in   (evt_in),
        .ovf_clr  (ovf_clr),
        .led_out  (led_out),
        .busy     (busy),
        .pend_cnt (pend_cnt),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  scen;
        logic [15:0] cyc;
        logic        led;
        logic        busy;
        logic [2:0]  pend;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;

    function automatic string rep(string c, int n);
        string s;
        s = "";
        for (int i = 0; i < n; i++) s = {s, c};
        return s;
    endfunction

    function automatic string z(int n);
        return rep("0", n);
    endfunction

    function automatic string o(int n);
        return rep("1", n);
    endfunction

    function automatic logic bit_at(string s, int i);
        if (i >= s.len()) return 1'b0;
        return (s[i] == 8'h31);
    endfunction

    function automatic logic [2:0] digit_at(string s, int i);
        byte ch;
        if (i >= s.len()) return 3'd0;
        ch = s[i];
        return 3'(ch - 8'h30);
    endfunction

    // Monitor: every cycle the DUT presents its outputs; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (led_out !== e.led || busy !== e.busy || pend_cnt !== e.pend || overflow !== e.ovf) begin
                    miscompares++;
                    $display("FAIL scen%0d cyc%0d led/busy/pend/ovf: got %b/%b/%0d/%b want %b/%b/%0d/%b",
                             e.scen, e.cyc, led_out, busy, pend_cnt, overflow,
                             e.led, e.busy, e.pend, e.ovf);
                end
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst     = 1'b1;
        evt_in  = 1'b1;
        ovf_clr = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic run(input int id, input string evt_s, input string clr_s, input string rst_s,
                       input string led_s, input string busy_s, input string pend_s,
                       input string ovf_s);
        exp_t e;
        for (int i = 0; i < led_s.len(); i++) begin
            @(posedge clk);
            #1;
            rst     = bit_at(rst_s, i);
            evt_in  = bit_at(evt_s, i);
            ovf_clr = bit_at(clr_s, i);
            e.scen  = 8'(id);
            e.cyc   = 16'(i);
            e.led   = bit_at(led_s, i);
            e.busy  = bit_at(busy_s, i);
            e.pend  = digit_at(pend_s, i);
            e.ovf   = bit_at(ovf_s, i);
            exp_q.push_back(e);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        evt_in      = 1'b0;
        ovf_clr     = 1'b0;

        // 1: single flash, then idle
        apply_reset();
        run(1, {o(1), z(9)}, "", "",
            {z(1), o(4), z(5)}, {z(1), o(7), z(2)}, z(10), z(10));

        // 2: second event during ON queues one more flash
        apply_reset();
        run(2, {o(1), z(1), o(1), z(14)}, "", "",
            {z(1), o(4), z(3), o(4), z(5)}, {z(1), o(14), z(2)},
            {z(3), o(5), z(9)}, z(17));

        // 3: event on the last ON cycle still queues
        apply_reset();
        run(3, {o(1), z(3), o(1), z(12)}, "", "",
            {z(1), o(4), z(3), o(4), z(5)}, {z(1), o(14), z(2)},
            {z(5), o(3), z(9)}, z(17));

        // 4: event at the GAP terminal cycle with empty queue is consumed directly
        apply_reset();
        run(4, {o(1), z(6), o(1), z(9)}, "", "",
            {z(1), o(4), z(3), o(4), z(5)}, {z(1), o(14), z(2)},
            z(17), z(17));

        // 5: five back-to-back events: saturation, one drop, four flashes
        apply_reset();
        run(5, {o(5), z(26)}, "", "",
            {z(1), o(4), z(3), o(4), z(3), o(4), z(3), o(4), z(5)},
            {z(1), o(28), z(2)},
            {z(2), rep("1", 1), rep("2", 1), rep("3", 4), rep("2", 7), rep("1", 7), z(9)},
            {z(5), o(26)});

        // 6: clear coinciding with a drop loses; clear alone wins the cycle after
        apply_reset();
        run(6, {o(6), z(4)}, {z(5), o(2), z(3)}, "",
            {z(1), o(4), z(3), o(2)}, {z(1), o(9)},
            {z(2), rep("1", 1), rep("2", 1), rep("3", 4), rep("2", 2)},
            {z(5), o(2), z(3)});

        // 7: reset mid-flash with pending events and an event in the same cycle
        apply_reset();
        run(7, {o(5), z(9)}, "", {z(3), o(2), z(9)},
            {z(1), o(3), z(10)}, {z(1), o(3), z(10)},
            {z(2), rep("1", 1), rep("2", 1), z(10)}, z(14));

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
